// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_W data bits LSB first, optional parity, one or two stop bits.
// Parity bit is compiled in only when UART_TX_FRAMER_PARITY_EN is defined.
module uart_tx_framer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 13,
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [CNT_W-1:0]  clks_per_bit,
  input  logic              two_stop,
  input  logic              parity_odd,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              txd
);

  // Handshake: a payload transfers on a rising edge where valid && ready; ready is high only in IDLE.
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]   r_n, w_n_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [DATA_W-1:0]  r_shift, w_shift_nxt;
  logic               r_two, w_two_nxt;
  logic               r_txd, w_txd_nxt;
  logic               r_done, w_done_nxt;
  logic               w_bit_end;

`ifdef UART_TX_FRAMER_PARITY_EN
  logic               r_par, w_par_nxt;
`else
  logic               w_unused_par;
  assign w_unused_par = parity_odd;
`endif

  assign ready = (r_state == S_IDLE);
  assign busy  = ~ready;
  assign done  = r_done;
  assign txd   = r_txd;

  assign w_bit_end = (r_cnt == r_n - CNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_n_nxt     = r_n;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_two_nxt   = r_two;
    w_txd_nxt   = r_txd;
    w_done_nxt  = 1'b0;
`ifdef UART_TX_FRAMER_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (r_state != S_IDLE) begin
      w_cnt_nxt = w_bit_end ? '0 : r_cnt + CNT_W'(1);
    end
    case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (valid) begin
          // A zero divisor would never end a bit, so it is promoted to 1.
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_n_nxt     = (clks_per_bit == '0) ? CNT_W'(1) : clks_per_bit;
          w_shift_nxt = data;
          w_two_nxt   = two_stop;
          w_txd_nxt   = 1'b0;
`ifdef UART_TX_FRAMER_PARITY_EN
          w_par_nxt   = (^data) ^ parity_odd;
`endif
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_txd_nxt   = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_idx == IDX_W'(DATA_W - 1)) begin
            w_idx_nxt = '0;
`ifdef UART_TX_FRAMER_PARITY_EN
            w_state_nxt = S_PARITY;
            w_txd_nxt   = r_par;
`else
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
`endif
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_shift_nxt = r_shift >> 1;
            w_txd_nxt   = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_idx_nxt   = '0;
          w_txd_nxt   = 1'b1;
        end
      end
      S_STOP: begin
        w_txd_nxt = 1'b1;
        if (w_bit_end) begin
          // r_idx counts stop bits already sent.
          if (!r_two || r_idx == IDX_W'(1)) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_n     <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_two   <= 1'b0;
      r_txd   <= 1'b1;
      r_done  <= 1'b0;
`ifdef UART_TX_FRAMER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_n     <= w_n_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_two   <= w_two_nxt;
      r_txd   <= w_txd_nxt;
      r_done  <= w_done_nxt;
`ifdef UART_TX_FRAMER_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, default 8: payload bits per frame, legal 5..9.
- CNT_W, default 13: width of the bit-period divisor.
REQ-002 The block SHALL have these ports:
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  synchronous, active-low reset.
- clks_per_bit  input  CNT_W  bit period in clk cycles.
- two_stop  input  1  1 = two stop bits, 0 = one stop bit.
- parity_odd  input  1  1 = odd parity, 0 = even (used only with UART_TX_FRAMER_PARITY_EN).
- data  input  DATA_W  payload.
- valid  input  1  payload offered.
- ready  output  1  block can accept a payload.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at end of frame.
- txd  output  1  serial line, idle high.

Function
REQ-003 The block SHALL accept a payload on any rising edge with valid=1 and ready=1, latching data, clks_per_bit, two_stop and parity_odd.
REQ-004 Latched settings SHALL govern the whole frame; input changes mid-frame SHALL have no effect.
REQ-005 ready SHALL be 1 only in IDLE and busy SHALL equal !ready.
REQ-006 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, with transitions:
- IDLE to START on accept.
- START to DATA.
- DATA to PARITY (if compiled) or STOP after bit DATA_W-1.
- PARITY to STOP.
- STOP to IDLE after the last stop bit.
REQ-007 Every bit, each stop bit included, SHALL hold txd for exactly N clk cycles, where N is the latched clks_per_bit, and a latched value of 0 SHALL be treated as 1.
REQ-008 Line levels SHALL be: START drives txd=0; DATA drives data bits LSB first; STOP drives txd=1 for one or two bit periods per two_stop.
REQ-009 txd SHALL be registered; it SHALL fall on the first clk edge after the accepting edge (latency 1 cycle).
REQ-010 Frame length SHALL be (1 + DATA_W + P + S) * N cycles, where P is 1 if parity is compiled in, else 0, and S is 1 or 2.
REQ-011 done SHALL pulse high for exactly one cycle, on the cycle IDLE is re-entered, with ready=1 in that same cycle.
REQ-012 Back-to-back: valid held high SHALL cause the next start bit to begin one cycle after done, with no idle bit period in between.
REQ-013 The bit-period counter SHALL be CNT_W wide and never wrap within a bit; the bit index SHALL be ceil(log2(DATA_W)) bits wide.
REQ-014 valid with ready=0 SHALL be ignored and no payload SHALL be queued.

Reset
REQ-015 While rstn=0 at a clk edge, the block SHALL set state IDLE, txd=1, ready=1, busy=0, done=0, and both counters to 0.
REQ-016 Reset asserted mid-frame SHALL abort the frame, with txd=1 the next cycle and no done pulse.

Configuration
REQ-017 With macro UART_TX_FRAMER_PARITY_EN defined, the block SHALL insert a PARITY bit after the data bits: the XOR of the data bits for even parity, inverted for odd.
REQ-018 Without UART_TX_FRAMER_PARITY_EN, PARITY SHALL be absent, parity_odd SHALL be ignored, and P=0.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- DATA_W=8, N=4, one stop, send 0xA5 -> txd 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; done at cycle 40 after accept.
- N=3, two_stop=1, send 0x00 -> low 27 cycles then high 6 cycles; done at cycle 33.
- Parity macro on, N=2, even, send 0x07 -> parity bit 1; odd -> 0; frame 22 cycles.
- valid held, 0x55 then 0xAA, N=2 -> start of second frame 1 cycle after first done pulse; ready low throughout frames.
- clks_per_bit=0 -> each bit lasts 1 cycle; frame length 10 cycles.
- rstn low at cycle 15 of an N=4 frame -> txd=1 next cycle, ready=1, no done; new accept then sends a full correct frame.
